// File: rtl/alu_req_arbiter_if.sv
// Signal bundle between requesters, response consumer and the shared ALU.
// slave = arbiter side, master = environment (requesters, consumer, ALU).
interface alu_req_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 32
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_rda;
    logic [NREQ*W-1:0] req_rdx;
    logic [NREQ*4-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic [W-1:0]      alu_rda;
    logic [W-1:0]      alu_rdx;
    logic [3:0]        alu_decode;
    logic [W-1:0]      alu_result;

    modport slave (
        input  req_valid, req_rda, req_rdx, req_op, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_rda, alu_rdx, alu_decode
    );

    modport master (
        output req_valid, req_rda, req_rdx, req_op, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
               alu_rda, alu_rdx, alu_decode
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters, one op in flight.
// Optional ALU_DIV0_CHECK_EN: trap DIV by zero locally (all-ones result, rsp_err=1).
module alu_req_arbiter #(
    parameter int NREQ   = 2,
    parameter int W      = 32,
    parameter int MD_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    alu_req_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(MD_LAT + 1);
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     rda_q, rda_d;
    logic [W-1:0]     rdx_q, rdx_d;
    logic [W-1:0]     res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic             bad_q, bad_d;
    logic             d0_q, d0_d;
    logic             err_q, err_d;

    logic [ID_W-1:0]  grant;
    logic [ID_W:0]    idx;
    logic             any_vld;
    logic [W-1:0]     sel_rda, sel_rdx;
    logic [3:0]       sel_op;
    logic             div0_sel;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0010, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    // Walk downward so the candidate closest to rr_ptr wins.
    always_comb begin
        grant   = rr_ptr_q;
        any_vld = 1'b0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
            if (bus.req_valid[idx[ID_W-1:0]]) begin
                grant   = idx[ID_W-1:0];
                any_vld = 1'b1;
            end
        end
    end

    assign sel_rda = bus.req_rda[int'(grant)*W +: W];
    assign sel_rdx = bus.req_rdx[int'(grant)*W +: W];
    assign sel_op  = bus.req_op[int'(grant)*4 +: 4];

`ifdef ALU_DIV0_CHECK_EN
    assign div0_sel = (sel_op == OP_DIV) && (sel_rdx == '0);
`else
    assign div0_sel = 1'b0;
`endif

    always_comb begin
        bus.req_ready = '0;
        if (state_q == IDLE && any_vld) bus.req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        rda_d    = rda_q;
        rdx_d    = rdx_q;
        op_d     = op_q;
        bad_d    = bad_q;
        d0_d     = d0_q;
        res_d    = res_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    state_d = EXEC;
                    id_d    = grant;
                    rda_d   = sel_rda;
                    rdx_d   = sel_rdx;
                    op_d    = sel_op;
                    bad_d   = !is_legal(sel_op);
                    d0_d    = div0_sel;
                    cnt_d   = ((sel_op == OP_MUL || sel_op == OP_DIV) && !div0_sel)
                              ? CNT_W'(MD_LAT - 1) : '0;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (bad_q) begin
                        res_d = '0;
                        err_d = 1'b1;
                    end else if (d0_q) begin
                        res_d = '1;
                        err_d = 1'b1;
                    end else begin
                        res_d = bus.alu_result;
                        err_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            rda_q    <= '0;
            rdx_q    <= '0;
            op_q     <= '0;
            bad_q    <= 1'b0;
            d0_q     <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            rda_q    <= rda_d;
            rdx_q    <= rdx_d;
            op_q     <= op_d;
            bad_q    <= bad_d;
            d0_q     <= d0_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    // Operands hold their last value outside EXEC; only the decode is forced idle.
    assign bus.alu_rda    = rda_q;
    assign bus.alu_rdx    = rdx_q;
    assign bus.alu_decode = (state_q == EXEC && !bad_q && !d0_q) ? op_q : 4'b0000;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a transaction-level reference model and ALU stub.
module tb_alu_req_arbiter;
    localparam int NREQ   = 2;
    localparam int W      = 32;
    localparam int MD_LAT = 4;
`ifdef ALU_DIV0_CHECK_EN
    localparam bit D0CHK = 1'b1;
`else
    localparam bit D0CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_req_arbiter_if #(.NREQ(NREQ), .W(W)) bus();

    alu_req_arbiter #(.NREQ(NREQ), .W(W), .MD_LAT(MD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] x);
        case (op)
            4'h1:    return a + x;
            4'h2:    return a - x;
            4'h5:    return a * x;
            4'h6:    return (x == '0) ? '1 : a / x;
            4'h7:    return a | x;
            4'h8:    return a & x;
            4'h9:    return a ^ x;
            4'hA:    return a << x[4:0];
            4'hB:    return a >> x[4:0];
            4'hC:    return W'($signed(a) < $signed(x));
            default: return '0;
        endcase
    endfunction

    always_comb bus.alu_result = alu_ref(bus.alu_decode, bus.alu_rda, bus.alu_rdx);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, counted in EXEC cycles before the response.
    bit              m_busy;
    int              m_left, m_rr, m_id, g, ix;
    logic [3:0]      m_dec, op_s;
    logic [W-1:0]    m_a, m_x, m_res;
    logic            m_err, m_d0, m_legal;
    logic [NREQ-1:0] exp_rdy;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_rr   = 0;
            m_id   = 0;
            m_a    = '0;
            m_x    = '0;
        end else begin
            exp_rdy = '0;
            g       = -1;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    ix = (m_rr + k) % NREQ;
                    if (g < 0 && bus.req_valid[ix]) g = ix;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("m_req_ready", W'(bus.req_ready), W'(exp_rdy));
            chk("m_rsp_valid", W'(bus.rsp_valid), W'(m_busy && m_left == 0));
            chk("m_alu_decode", W'(bus.alu_decode), W'((m_busy && m_left > 0) ? m_dec : 4'h0));
            chk("m_alu_rda", bus.alu_rda, m_a);
            chk("m_alu_rdx", bus.alu_rdx, m_x);
            if (m_busy && m_left == 0) begin
                chk("m_rsp_id", W'(bus.rsp_id), W'(m_id));
                chk("m_rsp_result", bus.rsp_result, m_res);
                chk("m_rsp_err", W'(bus.rsp_err), W'(m_err));
            end
            if (!m_busy) begin
                if (g >= 0) begin
                    op_s    = bus.req_op[g*4 +: 4];
                    m_a     = bus.req_rda[g*W +: W];
                    m_x     = bus.req_rdx[g*W +: W];
                    m_id    = g;
                    m_legal = op_s inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
                    m_d0    = D0CHK && op_s == 4'h6 && m_x == '0;
                    m_dec   = (m_legal && !m_d0) ? op_s : 4'h0;
                    m_left  = ((op_s == 4'h5 || op_s == 4'h6) && !m_d0) ? MD_LAT : 1;
                    if (!m_legal) begin
                        m_res = '0;
                        m_err = 1'b1;
                    end else if (m_d0) begin
                        m_res = '1;
                        m_err = 1'b1;
                    end else begin
                        m_res = alu_ref(op_s, m_a, m_x);
                        m_err = 1'b0;
                    end
                    m_busy = 1'b1;
                end
            end else if (m_left > 0) begin
                m_left--;
            end else if (bus.rsp_ready) begin
                m_busy = 1'b0;
                m_rr   = (m_id + 1) % NREQ;
            end
        end
    end

    task automatic drive(input int r, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] x);
        bus.req_op[r*4 +: 4]  = op;
        bus.req_rda[r*W +: W] = a;
        bus.req_rdx[r*W +: W] = x;
        bus.req_valid[r]      = 1'b1;
    endtask

    // Returns #1 after the handshake edge with the requester's valid dropped.
    task automatic wait_grant(input int r);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.req_ready[r]) begin
                @(posedge clk);
                #1 bus.req_valid[r] = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout: requester %0d got no grant, expected one within 50 cycles", r);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) return;
        end
        lat = -1;
    endtask

    int lat;
    int seq[8];
    int ng, nrsp;
    int cnt[NREQ];

    initial begin
        bus.req_valid = '0;
        bus.req_rda   = '0;
        bus.req_rdx   = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", W'(bus.rsp_valid), '0);
        chk("rst_req_ready", W'(bus.req_ready), '0);
        chk("rst_rsp_id", W'(bus.rsp_id), '0);
        chk("rst_rsp_result", bus.rsp_result, '0);
        chk("rst_rsp_err", W'(bus.rsp_err), '0);
        chk("rst_alu_rda", bus.alu_rda, '0);
        chk("rst_alu_rdx", bus.alu_rdx, '0);
        chk("rst_alu_decode", W'(bus.alu_decode), '0);

        // ADD 5+3 on requester 0
        drive(0, 4'h1, 32'd5, 32'd3);
        wait_grant(0);
        wait_rsp(lat);
        chk("add_latency", W'(lat), 32'd2);
        chk("add_id", W'(bus.rsp_id), 32'd0);
        chk("add_result", bus.rsp_result, 32'd8);
        chk("add_err", W'(bus.rsp_err), 32'd0);
        @(posedge clk); #1;

        // MUL 5*3 on requester 1, operands on the request bus scrambled after acceptance
        drive(1, 4'h5, 32'd5, 32'd3);
        wait_grant(1);
        bus.req_rda = {NREQ{32'hDEAD_0000}};
        bus.req_rdx = {NREQ{32'h0000_BEEF}};
        for (int c = 0; c < MD_LAT; c++) begin
            @(negedge clk);
            chk("mul_decode", W'(bus.alu_decode), 32'h5);
            chk("mul_rda", bus.alu_rda, 32'd5);
            chk("mul_rdx", bus.alu_rdx, 32'd3);
            chk("mul_early_valid", W'(bus.rsp_valid), '0);
        end
        @(negedge clk);
        chk("mul_valid", W'(bus.rsp_valid), 32'd1);
        chk("mul_result", bus.rsp_result, 32'd15);
        chk("mul_id", W'(bus.rsp_id), 32'd1);
        @(posedge clk); #1;

        // SRL with response backpressure and a second requester waiting
        bus.rsp_ready = 1'b0;
        drive(0, 4'hB, 32'h1234_5678, 32'd1);
        wait_grant(0);
        drive(1, 4'h1, 32'd1, 32'd1);
        wait_rsp(lat);
        chk("srl_latency", W'(lat), 32'd2);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk("srl_hold_valid", W'(bus.rsp_valid), 32'd1);
            chk("srl_hold_result", bus.rsp_result, 32'h091A_2B3C);
            chk("srl_hold_ready", W'(bus.req_ready), '0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_grant(1);
        wait_rsp(lat);
        chk("queued_add_result", bus.rsp_result, 32'd2);
        chk("queued_add_id", W'(bus.rsp_id), 32'd1);
        @(posedge clk); #1;

        // Illegal opcode
        drive(0, 4'hF, 32'd7, 32'd9);
        wait_grant(0);
        @(negedge clk);
        chk("ill_decode", W'(bus.alu_decode), '0);
        chk("ill_early_valid", W'(bus.rsp_valid), '0);
        @(negedge clk);
        chk("ill_valid", W'(bus.rsp_valid), 32'd1);
        chk("ill_err", W'(bus.rsp_err), 32'd1);
        chk("ill_result", bus.rsp_result, '0);
        @(posedge clk); #1;

        // DIV 10/0
        drive(1, 4'h6, 32'd10, 32'd0);
        wait_grant(1);
        wait_rsp(lat);
`ifdef ALU_DIV0_CHECK_EN
        chk("div0_latency", W'(lat), 32'd2);
        chk("div0_result", bus.rsp_result, 32'hFFFF_FFFF);
        chk("div0_err", W'(bus.rsp_err), 32'd1);
`else
        chk("div0_latency", W'(lat), W'(MD_LAT + 1));
        chk("div0_result", bus.rsp_result, 32'hFFFF_FFFF);
        chk("div0_err", W'(bus.rsp_err), 32'd0);
`endif
        @(posedge clk); #1;

        // Reset while a DIV is executing drops it
        drive(0, 4'h6, 32'd100, 32'd7);
        wait_grant(0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", W'(bus.rsp_valid), '0);
        chk("mid_rst_rsp_id", W'(bus.rsp_id), '0);
        chk("mid_rst_rsp_result", bus.rsp_result, '0);
        chk("mid_rst_rsp_err", W'(bus.rsp_err), '0);
        chk("mid_rst_alu_rda", bus.alu_rda, '0);
        chk("mid_rst_alu_rdx", bus.alu_rdx, '0);
        chk("mid_rst_decode", W'(bus.alu_decode), '0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", W'(bus.rsp_valid), '0);
        end
        @(posedge clk); #1;

        // Both requesters continuously valid with XOR 55^AA, four ops each
        ng   = 0;
        nrsp = 0;
        for (int r = 0; r < NREQ; r++) cnt[r] = 0;
        drive(0, 4'h9, 32'h55, 32'hAA);
        drive(1, 4'h9, 32'h55, 32'hAA);
        for (int n = 0; n < 100 && nrsp < 8; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                nrsp++;
                chk("xor_result", bus.rsp_result, 32'hFF);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (bus.req_ready[r] && bus.req_valid[r]) begin
                    if (ng < 8) seq[ng] = r;
                    ng++;
                    cnt[r]++;
                end
            end
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) if (cnt[r] >= 4) bus.req_valid[r] = 1'b0;
        end
        chk("xor_grants", W'(ng), 32'd8);
        chk("xor_responses", W'(nrsp), 32'd8);
        for (int k = 0; k < 8; k++) chk("xor_grant_order", W'(seq[k]), W'(k % 2));

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1, "watchdog");
    end
endmodule
